// File: rtl/halt_unit_pkg.sv
// Shared CPU definitions used by the retire-side halt detector.
package halt_unit_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned WORD_W   = 16;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } halt_state_e;

endpackage

// File: rtl/halt_unit.sv
// Retire-side halt detector: shadows the return register, counts retires and
// raises isHalt once outstanding stores have drained after a halt retires.
module halt_unit
    import halt_unit_pkg::*;
#(
    parameter int unsigned RET_REG   = 1,
    parameter int unsigned DRAIN_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic              wb_is_halt,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [WORD_W-1:0] wb_data,
    input  logic              mem_busy,
    output logic              fetch_stop,
    output logic              isHalt,
    output logic [WORD_W-1:0] ret_val,
    output logic [31:0]       instret,
    output logic              drain_timeout
);

    localparam int unsigned     CntW     = $clog2(DRAIN_MAX) + 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(DRAIN_MAX - 1);
    localparam logic [REG_W-1:0] RetIdx  = REG_W'(RET_REG);
    // r0 is hardwired zero, so a RET_REG of 0 never captures anything
    localparam logic            RetLive  = (RET_REG != 0);

    halt_state_e       state_q, state_d;
    logic              fetch_stop_q, fetch_stop_d;
    logic              is_halt_q, is_halt_d;
    logic              timeout_q, timeout_d;
    logic [WORD_W-1:0] ret_val_q, ret_val_d;
    logic [31:0]       instret_q, instret_d;
    logic [CntW-1:0]   dcnt_q, dcnt_d;

    always_comb begin
        state_d      = state_q;
        fetch_stop_d = fetch_stop_q;
        is_halt_d    = is_halt_q;
        timeout_d    = timeout_q;
        ret_val_d    = ret_val_q;
        instret_d    = instret_q;
        dcnt_d       = dcnt_q;

        unique case (state_q)
            StRun: begin
                if (wb_valid && wb_we && RetLive && (wb_rd == RetIdx)) begin
                    ret_val_d = wb_data;
                end
                if (wb_valid && (instret_q != 32'hFFFF_FFFF)) begin
                    instret_d = instret_q + 32'd1;
                end
                if (wb_valid && wb_is_halt) begin
                    state_d      = StDrain;
                    fetch_stop_d = 1'b1;
                    dcnt_d       = '0;
                end
            end
            StDrain: begin
                if (!mem_busy) begin
                    state_d   = StHalted;
                    is_halt_d = 1'b1;
                end else if (dcnt_q == CntLast) begin
                    state_d   = StHalted;
                    is_halt_d = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StHalted: begin
                is_halt_d    = 1'b1;
                fetch_stop_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StRun;
            fetch_stop_q <= 1'b0;
            is_halt_q    <= 1'b0;
            timeout_q    <= 1'b0;
            ret_val_q    <= '0;
            instret_q    <= '0;
            dcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            fetch_stop_q <= fetch_stop_d;
            is_halt_q    <= is_halt_d;
            timeout_q    <= timeout_d;
            ret_val_q    <= ret_val_d;
            instret_q    <= instret_d;
            dcnt_q       <= dcnt_d;
        end
    end

    assign fetch_stop    = fetch_stop_q;
    assign isHalt        = is_halt_q;
    assign ret_val       = ret_val_q;
    assign instret       = instret_q;
    assign drain_timeout = timeout_q;

endmodule
